// File: rtl/gates_mux_pkg.sv
// Shared constants and gate-kind enumeration for the mux-built gate unit.
// The extended gate outputs are enabled by GATES_MUX_EXT_EN in the top.
package gates_mux_pkg;

    localparam logic LOGIC_ZERO = 1'b0;
    localparam logic LOGIC_ONE  = 1'b1;

    typedef enum logic [2:0] {
        GATE_AND  = 3'd0,
        GATE_OR   = 3'd1,
        GATE_NOT  = 3'd2,
        GATE_NAND = 3'd3,
        GATE_NOR  = 3'd4,
        GATE_XOR  = 3'd5,
        GATE_XNOR = 3'd6
    } gate_kind_e;

endpackage : gates_mux_pkg

// File: rtl/gates_mux_mux2.sv
// 1-bit 2:1 multiplexer cell (mux2); the only primitive used to build gates.
module gates_mux_mux2 (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule : gates_mux_mux2

// File: rtl/gates_mux.sv
// Bitwise AND/OR/NOT unit built purely from mux2 cells, optionally registered.
// Define GATES_MUX_EXT_EN to add NAND/NOR/XOR/XNOR outputs.
module gates_mux
    import gates_mux_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter bit          REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] and_out,
    output logic [WIDTH-1:0] or_out,
    output logic [WIDTH-1:0] not_out
`ifdef GATES_MUX_EXT_EN
    ,
    output logic [WIDTH-1:0] nand_out,
    output logic [WIDTH-1:0] nor_out,
    output logic [WIDTH-1:0] xor_out,
    output logic [WIDTH-1:0] xnor_out
`endif
);

    logic [WIDTH-1:0] and_d;
    logic [WIDTH-1:0] or_d;
    logic [WIDTH-1:0] not_d;
`ifdef GATES_MUX_EXT_EN
    logic [WIDTH-1:0] nb_d;
    logic [WIDTH-1:0] nand_d;
    logic [WIDTH-1:0] nor_d;
    logic [WIDTH-1:0] xor_d;
    logic [WIDTH-1:0] xnor_d;
`endif

    // Per-bit gate fabric: every gate is a mux2 selected by a[i].
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        gates_mux_mux2 u_and (.sel(a[i]), .d0(LOGIC_ZERO), .d1(b[i]),      .y(and_d[i]));
        gates_mux_mux2 u_or  (.sel(a[i]), .d0(b[i]),       .d1(LOGIC_ONE), .y(or_d[i]));
        gates_mux_mux2 u_not (.sel(a[i]), .d0(LOGIC_ONE),  .d1(LOGIC_ZERO), .y(not_d[i]));
`ifdef GATES_MUX_EXT_EN
        // Local inverse of b, itself a NOT-configured mux selected by b[i].
        gates_mux_mux2 u_nb   (.sel(b[i]), .d0(LOGIC_ONE), .d1(LOGIC_ZERO), .y(nb_d[i]));
        gates_mux_mux2 u_nand (.sel(a[i]), .d0(LOGIC_ONE), .d1(nb_d[i]),   .y(nand_d[i]));
        gates_mux_mux2 u_nor  (.sel(a[i]), .d0(nb_d[i]),   .d1(LOGIC_ZERO), .y(nor_d[i]));
        gates_mux_mux2 u_xor  (.sel(a[i]), .d0(b[i]),      .d1(nb_d[i]),   .y(xor_d[i]));
        gates_mux_mux2 u_xnor (.sel(a[i]), .d0(nb_d[i]),   .d1(b[i]),      .y(xnor_d[i]));
`endif
    end

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] and_q;
        logic [WIDTH-1:0] or_q;
        logic [WIDTH-1:0] not_q;
`ifdef GATES_MUX_EXT_EN
        logic [WIDTH-1:0] nand_q;
        logic [WIDTH-1:0] nor_q;
        logic [WIDTH-1:0] xor_q;
        logic [WIDTH-1:0] xnor_q;
`endif

        // Reset clears every output, not_out included, and wins over data.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                and_q  <= '0;
                or_q   <= '0;
                not_q  <= '0;
`ifdef GATES_MUX_EXT_EN
                nand_q <= '0;
                nor_q  <= '0;
                xor_q  <= '0;
                xnor_q <= '0;
`endif
            end else begin
                and_q  <= and_d;
                or_q   <= or_d;
                not_q  <= not_d;
`ifdef GATES_MUX_EXT_EN
                nand_q <= nand_d;
                nor_q  <= nor_d;
                xor_q  <= xor_d;
                xnor_q <= xnor_d;
`endif
            end
        end

        assign and_out  = and_q;
        assign or_out   = or_q;
        assign not_out  = not_q;
`ifdef GATES_MUX_EXT_EN
        assign nand_out = nand_q;
        assign nor_out  = nor_q;
        assign xor_out  = xor_q;
        assign xnor_out = xnor_q;
`endif
    end else begin : g_comb
        // Clock and reset have no function in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign and_out  = and_d;
        assign or_out   = or_d;
        assign not_out  = not_d;
`ifdef GATES_MUX_EXT_EN
        assign nand_out = nand_d;
        assign nor_out  = nor_d;
        assign xor_out  = xor_d;
        assign xnor_out = xnor_d;
`endif
    end

endmodule : gates_mux

// File: tb/tb_gates_mux.sv
// Randomized self-checking bench for gates_mux against a boolean reference model.
// Covers registered (WIDTH=4 and WIDTH=1) and combinational instances.
module tb_gates_mux;
    import gates_mux_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] a4, b4, ac, bc;
    logic       a1, b1;

    logic [3:0] and4, or4, not4, andc, orc, notc;
    logic       and1, or1, not1;
`ifdef GATES_MUX_EXT_EN
    logic [3:0] nand4, nor4, xor4, xnor4, nandc, norc, xorc, xnorc;
    logic       nand1, nor1, xor1, xnor1;
`endif

    int vectors;
    int miscompares;

    gates_mux #(.WIDTH(4), .REG_OUT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4),
        .and_out(and4), .or_out(or4), .not_out(not4)
`ifdef GATES_MUX_EXT_EN
        , .nand_out(nand4), .nor_out(nor4), .xor_out(xor4), .xnor_out(xnor4)
`endif
    );

    gates_mux #(.WIDTH(1), .REG_OUT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1),
        .and_out(and1), .or_out(or1), .not_out(not1)
`ifdef GATES_MUX_EXT_EN
        , .nand_out(nand1), .nor_out(nor1), .xor_out(xor1), .xnor_out(xnor1)
`endif
    );

    gates_mux #(.WIDTH(4), .REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .a(ac), .b(bc),
        .and_out(andc), .or_out(orc), .not_out(notc)
`ifdef GATES_MUX_EXT_EN
        , .nand_out(nandc), .nor_out(norc), .xor_out(xorc), .xnor_out(xnorc)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_gate(gate_kind_e k, logic [3:0] x, logic [3:0] y);
        case (k)
            GATE_AND:  return x & y;
            GATE_OR:   return x | y;
            GATE_NOT:  return ~x;
            GATE_NAND: return ~(x & y);
            GATE_NOR:  return ~(x | y);
            GATE_XOR:  return x ^ y;
            GATE_XNOR: return ~(x ^ y);
            default:   return 4'hx;
        endcase
    endfunction

    function automatic logic [11:0] ref_base(logic [3:0] x, logic [3:0] y);
        return {ref_gate(GATE_AND, x, y), ref_gate(GATE_OR, x, y), ref_gate(GATE_NOT, x, y)};
    endfunction

    function automatic logic [15:0] ref_ext(logic [3:0] x, logic [3:0] y);
        return {ref_gate(GATE_NAND, x, y), ref_gate(GATE_NOR, x, y),
                ref_gate(GATE_XOR, x, y), ref_gate(GATE_XNOR, x, y)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a4 = 4'hF; b4 = 4'hF; a1 = 1'b1; b1 = 1'b1; ac = 4'hF; bc = 4'hF;
        for (int e = 0; e < 2; e++) begin
            @(posedge clk); #1;
            vectors++;
            if ({and4, or4, not4} !== 12'h000) begin
                miscompares++;
                $display("FAIL reset_w4 edge%0d: got %h expected 000", e, {and4, or4, not4});
            end
            vectors++;
            if ({and1, or1, not1} !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_w1 edge%0d: got %b expected 000", e, {and1, or1, not1});
            end
`ifdef GATES_MUX_EXT_EN
            vectors++;
            if ({nand4, nor4, xor4, xnor4} !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_ext edge%0d: got %h expected 0000", e, {nand4, nor4, xor4, xnor4});
            end
`endif
            vectors++;
            if ({andc, orc, notc} !== ref_base(4'hF, 4'hF)) begin
                miscompares++;
                $display("FAIL reset_comb_live edge%0d: got %h expected %h", e, {andc, orc, notc},
                         ref_base(4'hF, 4'hF));
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table();
        logic [2:0] exp_tbl [4];
        exp_tbl[0] = 3'b001; exp_tbl[1] = 3'b011; exp_tbl[2] = 3'b010; exp_tbl[3] = 3'b110;
        for (int v = 0; v < 4; v++) begin
            a1 = v[1]; b1 = v[0];
            @(posedge clk); #1;
            vectors++;
            if ({and1, or1, not1} !== exp_tbl[v]) begin
                miscompares++;
                $display("FAIL truth_w1 ab=%0d%0d: got %b expected %b", a1, b1, {and1, or1, not1}, exp_tbl[v]);
            end
        end
    endtask

    task automatic test_comb();
        logic [2:0] exp_tbl [4];
        exp_tbl[0] = 3'b001; exp_tbl[1] = 3'b011; exp_tbl[2] = 3'b010; exp_tbl[3] = 3'b110;
        for (int v = 0; v < 4; v++) begin
            ac = {3'b000, v[1]}; bc = {3'b000, v[0]};
            rst_n = v[0];
            #1;
            vectors++;
            if ({andc[0], orc[0], notc[0]} !== exp_tbl[v]) begin
                miscompares++;
                $display("FAIL comb_truth ab=%0d%0d: got %b expected %b", ac[0], bc[0],
                         {andc[0], orc[0], notc[0]}, exp_tbl[v]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_vector();
        a4 = 4'b1100; b4 = 4'b1010;
        @(posedge clk); #1;
        vectors++;
        if ({and4, or4, not4} !== {4'b1000, 4'b1110, 4'b0011}) begin
            miscompares++;
            $display("FAIL vector_w4: got %b_%b_%b expected 1000_1110_0011", and4, or4, not4);
        end
`ifdef GATES_MUX_EXT_EN
        vectors++;
        if ({nand4, nor4, xor4, xnor4} !== {4'b0111, 4'b0001, 4'b0110, 4'b1001}) begin
            miscompares++;
            $display("FAIL vector_ext: got %b_%b_%b_%b expected 0111_0001_0110_1001",
                     nand4, nor4, xor4, xnor4);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        a1 = 1'b1; b1 = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (and1 !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_pre: got and=%b expected 1", and1);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({and1, or1, not1} !== 3'b000) begin
            miscompares++;
            $display("FAIL midrst_hold: got %b expected 000", {and1, or1, not1});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({and1, or1, not1} !== 3'b110) begin
            miscompares++;
            $display("FAIL midrst_post: got %b expected 110", {and1, or1, not1});
        end
    endtask

    task automatic test_random();
        logic [11:0] prev_base, exp_base;
        logic [15:0] prev_ext, exp_ext;
        prev_base = {and4, or4, not4};
        prev_ext  = ref_ext(4'b1100, 4'b1010);
        for (int n = 0; n < 300; n++) begin
            a4 = 4'($urandom); b4 = 4'($urandom);
            ac = 4'($urandom); bc = 4'($urandom);
            rst_n = ($urandom_range(0, 9) != 0);
            #1;
            vectors++;
            if ({andc, orc, notc} !== ref_base(ac, bc)) begin
                miscompares++;
                $display("FAIL rand_comb n=%0d: got %h expected %h", n, {andc, orc, notc}, ref_base(ac, bc));
            end
`ifdef GATES_MUX_EXT_EN
            vectors++;
            if ({nandc, norc, xorc, xnorc} !== ref_ext(ac, bc)) begin
                miscompares++;
                $display("FAIL rand_comb_ext n=%0d: got %h expected %h", n,
                         {nandc, norc, xorc, xnorc}, ref_ext(ac, bc));
            end
            vectors++;
            if ({nand4, nor4, xor4, xnor4} !== prev_ext) begin
                miscompares++;
                $display("FAIL rand_hold_ext n=%0d: got %h expected %h", n, {nand4, nor4, xor4, xnor4}, prev_ext);
            end
`endif
            vectors++;
            if ({and4, or4, not4} !== prev_base) begin
                miscompares++;
                $display("FAIL rand_hold n=%0d: got %h expected %h", n, {and4, or4, not4}, prev_base);
            end
            exp_base = rst_n ? ref_base(a4, b4) : 12'h000;
            exp_ext  = rst_n ? ref_ext(a4, b4) : 16'h0000;
            @(posedge clk); #1;
            vectors++;
            if ({and4, or4, not4} !== exp_base) begin
                miscompares++;
                $display("FAIL rand_reg n=%0d a=%b b=%b rst_n=%b: got %h expected %h", n, a4, b4, rst_n,
                         {and4, or4, not4}, exp_base);
            end
`ifdef GATES_MUX_EXT_EN
            vectors++;
            if ({nand4, nor4, xor4, xnor4} !== exp_ext) begin
                miscompares++;
                $display("FAIL rand_reg_ext n=%0d: got %h expected %h", n, {nand4, nor4, xor4, xnor4}, exp_ext);
            end
`endif
            prev_base = exp_base;
            prev_ext  = exp_ext;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_truth_table();
        test_comb();
        test_vector();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_gates_mux
